// File: rtl/wb_host_pkg.sv
// Shared types and widths for the Wishbone host master: bus widths, FSM state
// encoding and the packed command record held in the command FIFO.
package wb_host_pkg;

    localparam int WB_ADR_W = 10;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    localparam int WB_CMD_W = 1 + WB_ADR_W + WB_DAT_W + WB_SEL_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CYCLE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_cmd_t;

    function automatic wb_cmd_t make_cmd(
        input logic                we,
        input logic [WB_ADR_W-1:0] adr,
        input logic [WB_DAT_W-1:0] dat,
        input logic [WB_SEL_W-1:0] sel
    );
        wb_cmd_t c;
        c.we  = we;
        c.adr = adr;
        c.dat = dat;
        c.sel = sel;
        return c;
    endfunction

endpackage

// File: rtl/wb_host_master_if.sv
// Host command/response channels plus the Wishbone classic master bus, bundled
// so the master and its surroundings (host sequencer and register slave) share one view.
interface wb_host_master_if;
    import wb_host_pkg::*;

    // Both channels transfer on a rising edge where valid && ready; valid
    // holds its payload stable until that edge and never waits on ready.
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic                cmd_we_i;
    logic [WB_ADR_W-1:0] cmd_adr_i;
    logic [WB_DAT_W-1:0] cmd_dat_i;
    logic [WB_SEL_W-1:0] cmd_sel_i;

    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [WB_DAT_W-1:0] rsp_dat_o;
    logic                rsp_err_o;
    logic                rsp_timeout_o;

    logic [WB_ADR_W-1:0] wb_adr_o;
    logic [WB_DAT_W-1:0] wb_dat_o;
    logic [WB_SEL_W-1:0] wb_sel_o;
    logic                wb_we_o;
    logic                wb_stb_o;
    logic                wb_cyc_o;
    logic [WB_DAT_W-1:0] wb_dat_i;
    logic                wb_ack_i;
    logic                wb_err_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        input  rsp_ready_i,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        output rsp_ready_i,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/wb_host_cmd_fifo.sv
// Synchronous FIFO of wb_cmd_t with combinational head read; pointers wrap
// naturally because DEPTH is a power of two.
module wb_host_cmd_fifo
    import wb_host_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_cmd_t push_data,
    input  logic    pop,
    output wb_cmd_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    wb_cmd_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      cnt <= cnt + 1'b1;
            else if (pop_ok && !push_ok) cnt <= cnt - 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic master: queues host commands and runs one single bus cycle per
// command. Optional watchdog abort is enabled by WB_HOST_MASTER_TIMEOUT_EN.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int CMD_DEPTH = 4
`ifdef WB_HOST_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    wb_host_master_if.master bus,
    output state_t           state_o
);

    state_t               state_q, state_n;
    wb_cmd_t              bus_q, bus_n;
    logic                 cyc_q, cyc_n;
    logic                 rsp_valid_q, rsp_valid_n;
    logic [WB_DAT_W-1:0]  rsp_dat_q, rsp_dat_n;
    logic                 rsp_err_q, rsp_err_n;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic                 rsp_to_q, rsp_to_n;
    logic [15:0]          wdog_q, wdog_n;
`endif

    wb_cmd_t fifo_head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_pop;

    wb_host_cmd_fifo #(
        .DEPTH(CMD_DEPTH)
    ) u_cmd_fifo (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_i),
        .push     (bus.cmd_valid_i && !fifo_full),
        .push_data(make_cmd(bus.cmd_we_i, bus.cmd_adr_i, bus.cmd_dat_i, bus.cmd_sel_i)),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_n     = state_q;
        bus_n       = bus_q;
        cyc_n       = cyc_q;
        rsp_valid_n = rsp_valid_q;
        rsp_dat_n   = rsp_dat_q;
        rsp_err_n   = rsp_err_q;
        fifo_pop    = 1'b0;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
        rsp_to_n    = rsp_to_q;
        wdog_n      = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    bus_n    = fifo_head;
                    cyc_n    = 1'b1;
                    state_n  = CYCLE;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
                    wdog_n   = '0;
`endif
                end
            end
            CYCLE: begin
                // err outranks ack, and any termination outranks the watchdog.
                if (bus.wb_ack_i || bus.wb_err_i) begin
                    cyc_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = bus.wb_err_i;
                    rsp_dat_n   = (bus.wb_err_i || bus_q.we) ? '0 : bus.wb_dat_i;
                    state_n     = RESP;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
                    rsp_to_n    = 1'b0;
                end else if (wdog_q == WDOG_LAST) begin
                    cyc_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b0;
                    rsp_dat_n   = '0;
                    rsp_to_n    = 1'b1;
                    state_n     = RESP;
                end else begin
                    wdog_n      = wdog_q + 16'd1;
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q     <= IDLE;
            bus_q       <= '0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
            rsp_to_q    <= 1'b0;
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_n;
            bus_q       <= bus_n;
            cyc_q       <= cyc_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_dat_q   <= rsp_dat_n;
            rsp_err_q   <= rsp_err_n;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
            rsp_to_q    <= rsp_to_n;
            wdog_q      <= wdog_n;
`endif
        end
    end

    assign bus.cmd_ready_o = !fifo_full;
    assign bus.wb_adr_o    = bus_q.adr;
    assign bus.wb_dat_o    = bus_q.dat;
    assign bus.wb_sel_o    = bus_q.sel;
    assign bus.wb_we_o     = bus_q.we;
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout_o = rsp_to_q;
`else
    assign bus.rsp_timeout_o = 1'b0;
`endif
    assign state_o = state_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master: directed vector table, randomized
// transactions against a response model, FIFO fill/order, reset and timeout sequences.
module tb_wb_host_master;
    import wb_host_pkg::*;

    localparam int CMD_DEPTH = 4;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 8;
`endif

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dut_state;
    int     n_checks = 0;
    int     n_pass = 0;
    logic [WB_CMD_W-1:0] exp_q[$];

    typedef struct {
        wb_cmd_t     cmd;
        int          waits;
        int          mode;      // 0 ack, 1 err, 2 ack+err together
        logic [31:0] rdata;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    wb_host_master_if bus();

    wb_host_master #(
        .CMD_DEPTH(CMD_DEPTH)
`ifdef WB_HOST_MASTER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst_n),
        .bus     (bus),
        .state_o (dut_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic wb_cmd_t observed();
        return make_cmd(bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o);
    endfunction

    // Reference model of a completed cycle: {err, rsp_dat}.
    function automatic logic [32:0] model_rsp(input logic we, input int mode, input logic [31:0] rdata);
        if (mode != 0) return {1'b1, 32'h0};
        if (we)        return {1'b0, 32'h0};
        return {1'b0, rdata};
    endfunction

    function automatic wb_cmd_t rand_cmd();
        return make_cmd(1'($urandom_range(0, 1)), 10'($urandom), 32'($urandom), 4'($urandom));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_cmd(input wb_cmd_t c);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = c.we;
        bus.cmd_adr_i   = c.adr;
        bus.cmd_dat_i   = c.dat;
        bus.cmd_sel_i   = c.sel;
    endtask

    task automatic run_txn(input wb_cmd_t c, input int waits, input int mode,
                           input logic [31:0] rdata, input logic [31:0] exp_dat,
                           input logic exp_err, input string tag);
        int   stb_seen;
        logic stable;
        int   hold;
        drive_cmd(c);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        chk({tag, "_lat_pre"}, 64'(bus.wb_cyc_o), 64'(0));
        @(negedge clk);
        chk({tag, "_cyc_on"}, 64'(bus.wb_cyc_o && bus.wb_stb_o), 64'(1));
        chk({tag, "_bus"}, 64'(observed()), 64'(c));
        stb_seen = 0;
        stable   = 1'b1;
        for (int k = 0; k <= waits; k++) begin
            if (bus.wb_cyc_o && bus.wb_stb_o) stb_seen++;
            if (observed() != c) stable = 1'b0;
            bus.wb_dat_i = 32'($urandom);
            if (k == waits) begin
                bus.wb_ack_i = (mode != 1);
                bus.wb_err_i = (mode != 0);
                bus.wb_dat_i = rdata;
            end
            @(negedge clk);
        end
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_dat_i = 32'($urandom);
        chk({tag, "_stb_len"}, 64'(stb_seen), 64'(waits + 1));
        chk({tag, "_stable"}, 64'(stable), 64'(1));
        chk({tag, "_cyc_off"}, 64'(bus.wb_cyc_o || bus.wb_stb_o), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'(1));
        chk({tag, "_rsp_dat"}, 64'(bus.rsp_dat_o), 64'(exp_dat));
        chk({tag, "_rsp_err"}, 64'(bus.rsp_err_o), 64'(exp_err));
        chk({tag, "_rsp_to"}, 64'(bus.rsp_timeout_o), 64'(0));
        hold = $urandom_range(0, 2);
        repeat (hold) @(negedge clk);
        chk({tag, "_rsp_hold"}, 64'({bus.rsp_valid_o, bus.rsp_dat_o}), 64'({1'b1, exp_dat}));
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        chk({tag, "_rsp_done"}, 64'(bus.rsp_valid_o), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [32:0] m;
        wb_cmd_t     c;
        int          seen;
        int          last_start;
        int          strobes;
        int          rsps;

        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = '0;
        bus.cmd_dat_i   = '0;
        bus.cmd_sel_i   = '0;
        bus.rsp_ready_i = 1'b0;
        bus.wb_dat_i    = '0;
        bus.wb_ack_i    = 1'b0;
        bus.wb_err_i    = 1'b0;

        vecs[0] = '{make_cmd(1'b1, 10'h010, 32'h0000_A5A5, 4'hF), 0, 0, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[1] = '{make_cmd(1'b0, 10'h014, 32'h0, 4'hF), 3, 0, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[2] = '{make_cmd(1'b0, 10'h020, 32'h0, 4'h3), 1, 2, 32'hCAFE_F00D, 32'h0, 1'b1};
        vecs[3] = '{make_cmd(1'b1, 10'h3FF, 32'hFFFF_FFFF, 4'h5), 2, 1, 32'h5555_AAAA, 32'h0, 1'b1};
        vecs[4] = '{make_cmd(1'b0, 10'h000, 32'h0, 4'h1), 0, 0, 32'h8000_0001, 32'h8000_0001, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cyc", 64'(bus.wb_cyc_o), 64'(0));
        chk("rst_stb", 64'(bus.wb_stb_o), 64'(0));
        chk("rst_adr", 64'(bus.wb_adr_o), 64'(0));
        chk("rst_dat", 64'(bus.wb_dat_o), 64'(0));
        chk("rst_sel", 64'(bus.wb_sel_o), 64'(0));
        chk("rst_we", 64'(bus.wb_we_o), 64'(0));
        chk("rst_ready", 64'(bus.cmd_ready_o), 64'(1));
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("rst_rsp_dat", 64'(bus.rsp_dat_o), 64'(0));
        chk("rst_rsp_err", 64'(bus.rsp_err_o), 64'(0));
        chk("rst_rsp_to", 64'(bus.rsp_timeout_o), 64'(0));
        chk("rst_state", 64'(dut_state), 64'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 5; i++)
            run_txn(vecs[i].cmd, vecs[i].waits, vecs[i].mode, vecs[i].rdata,
                    vecs[i].exp_dat, vecs[i].exp_err, $sformatf("vec%0d", i));

        // Randomized transactions against the response model
        for (int i = 0; i < 24; i++) begin
            int          waits;
            int          mode;
            logic [31:0] rdata;
            c     = rand_cmd();
            waits = $urandom_range(0, 3);
            mode  = $urandom_range(0, 5);
            mode  = (mode <= 3) ? 0 : mode - 3;
            rdata = 32'($urandom);
            m     = model_rsp(c.we, mode, rdata);
            run_txn(c, waits, mode, rdata, m[31:0], m[32], $sformatf("rnd%0d", i));
        end

        // Ack/err outside CYCLE is ignored
        bus.wb_ack_i = 1'b1;
        bus.wb_err_i = 1'b1;
        bus.wb_dat_i = 32'h7777_7777;
        repeat (2) @(negedge clk);
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        chk("stray_ack_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("stray_ack_cyc", 64'(bus.wb_cyc_o), 64'(0));

        // FIFO fill with response stalled; order and blocking checked after drain
        for (int i = 0; i < 5; i++) begin
            c = rand_cmd();
            chk($sformatf("fifo_ready%0d", i), 64'(bus.cmd_ready_o), 64'(1));
            drive_cmd(c);
            exp_q.push_back(c);
            @(negedge clk);
        end
        bus.cmd_valid_i = 1'b0;
        chk("fifo_full", 64'(bus.cmd_ready_o), 64'(0));
        drive_cmd(rand_cmd());
        repeat (2) @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        chk("fifo_still_full", 64'(bus.cmd_ready_o), 64'(0));
        bus.rsp_ready_i = 1'b1;
        seen = 0;
        last_start = 0;
        for (int t = 0; t < 60 && seen < 5; t++) begin
            bus.wb_ack_i = 1'b0;
            if (bus.wb_cyc_o && bus.wb_stb_o) begin
                if (exp_q.size() > 0) chk($sformatf("fifo_order%0d", seen), 64'(observed()), 64'(exp_q.pop_front()));
                if (seen > 0) chk($sformatf("fifo_gap%0d", seen), 64'(t - last_start), 64'(3));
                last_start = t;
                seen++;
                bus.wb_ack_i = 1'b1;
                bus.wb_dat_i = 32'($urandom);
            end
            @(negedge clk);
        end
        bus.wb_ack_i = 1'b0;
        chk("fifo_drained", 64'(seen), 64'(5));
        chk("fifo_sb_empty", 64'(exp_q.size()), 64'(0));
        strobes = 0;
        for (int t = 0; t < 6; t++) begin
            if (bus.wb_cyc_o) strobes++;
            @(negedge clk);
        end
        chk("fifo_no_extra", 64'(strobes), 64'(0));
        chk("fifo_ready_again", 64'(bus.cmd_ready_o), 64'(1));
        bus.rsp_ready_i = 1'b0;

        // Reset during CYCLE with two commands queued
        for (int i = 0; i < 3; i++) begin
            drive_cmd(rand_cmd());
            @(negedge clk);
        end
        bus.cmd_valid_i = 1'b0;
        chk("rstmid_cyc_before", 64'(bus.wb_cyc_o), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_cyc", 64'(bus.wb_cyc_o || bus.wb_stb_o), 64'(0));
        chk("rstmid_rsp", 64'(bus.rsp_valid_o), 64'(0));
        chk("rstmid_ready", 64'(bus.cmd_ready_o), 64'(1));
        rst_n = 1'b1;
        bus.rsp_ready_i = 1'b1;
        strobes = 0;
        rsps = 0;
        for (int t = 0; t < 10; t++) begin
            bus.wb_ack_i = bus.wb_cyc_o;
            if (bus.wb_cyc_o) strobes++;
            if (bus.rsp_valid_o) rsps++;
            @(negedge clk);
        end
        bus.wb_ack_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        chk("rstmid_no_strobe", 64'(strobes), 64'(0));
        chk("rstmid_no_rsp", 64'(rsps), 64'(0));

`ifdef WB_HOST_MASTER_TIMEOUT_EN
        // Silent slave: watchdog aborts after TIMEOUT_CYCLES strobe cycles
        drive_cmd(make_cmd(1'b0, 10'h044, 32'h0, 4'hF));
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        strobes = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.wb_cyc_o) strobes++;
            else if (strobes > 0) break;
        end
        chk("to_len", 64'(strobes), 64'(TIMEOUT_CYCLES));
        chk("to_rsp", 64'({bus.rsp_valid_o, bus.rsp_timeout_o, bus.rsp_err_o}), 64'(3'b110));
        chk("to_dat", 64'(bus.rsp_dat_o), 64'(0));
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h1111_2222;
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        chk("to_late_ack", 64'({bus.rsp_valid_o, bus.rsp_timeout_o, bus.rsp_dat_o}), 64'({2'b11, 32'h0}));
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        run_txn(make_cmd(1'b0, 10'h048, 32'h0, 4'hF), 1, 0, 32'hABCD_0123, 32'hABCD_0123, 1'b0, "to_next");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
